// File: rtl/armleocpu_store_splitter.sv
// Store data path: turns one CPU store into one or two lane-aligned bus write
// beats with byte strobes, then reports a single completion with status.
module armleocpu_store_splitter #(
  parameter int DATA_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [1:0]              req_type,
  input  logic [DATA_WIDTH-1:0]   req_data,

  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic [31:0]             bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_data,
  output logic [DATA_WIDTH/8-1:0] bus_strb,
  input  logic                    bus_bvalid,
  input  logic                    bus_berror,

  output logic                    done_valid,
  output logic                    done_error,
  output logic                    done_missaligned,
  output logic                    done_unknowntype
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int SW    = 2 * BYTES;
  localparam int DW2   = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND0,
    S_SEND1,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic                  bus_valid_n;
  logic [31:0]           bus_addr_n;
  logic [DATA_WIDTH-1:0] bus_data_n;
  logic [BYTES-1:0]      bus_strb_n;
  logic                  done_valid_n, done_error_n, done_miss_n, done_unk_n;
  logic [1:0]            rsp_cnt, rsp_cnt_n;
  logic                  split_q, split_n;
  logic [31:0]           b1_addr, b1_addr_n;
  logic [DATA_WIDTH-1:0] b1_data, b1_data_n;
  logic [BYTES-1:0]      b1_strb, b1_strb_n;

  // Request decode, only meaningful in the accept cycle
  logic [OFS-1:0] off;
  logic [SW-1:0]  mask, strb_wide;
  logic [DW2-1:0] data_wide;
  logic [2:0]     align;
  logic [31:0]    base;
  logic           misaligned, split, unknown;

  assign off  = req_addr[OFS-1:0];
  assign base = {req_addr[31:OFS], {OFS{1'b0}}};

  always_comb begin
    mask  = '0;
    align = '0;
    case (req_type)
      2'd0: begin mask = SW'(8'h01); align = 3'd0; end
      2'd1: begin mask = SW'(8'h03); align = 3'd1; end
      2'd2: begin mask = SW'(8'h0F); align = 3'd3; end
      default: begin mask = SW'(8'hFF); align = 3'd7; end
    endcase
  end

  // The upper half of the double-width shift is exactly the second beat
  assign strb_wide  = mask << off;
  assign data_wide  = DW2'(req_data) << {off, 3'b000};
  assign misaligned = (3'(off) & align) != 3'd0;
  assign split      = |strb_wide[SW-1:BYTES];
  assign unknown    = (req_type == 2'd3) && (DATA_WIDTH < 64);

  assign req_ready = (state == S_IDLE);

  always_comb begin
    state_n      = state;
    bus_valid_n  = bus_valid;
    bus_addr_n   = bus_addr;
    bus_data_n   = bus_data;
    bus_strb_n   = bus_strb;
    done_valid_n = 1'b0;
    done_error_n = done_error;
    done_miss_n  = done_missaligned;
    done_unk_n   = done_unknowntype;
    rsp_cnt_n    = rsp_cnt;
    split_n      = split_q;
    b1_addr_n    = b1_addr;
    b1_data_n    = b1_data;
    b1_strb_n    = b1_strb;

    // Responses may arrive while beats are still being issued
    if (bus_bvalid && state != S_IDLE && state != S_DONE) begin
      rsp_cnt_n    = rsp_cnt + 2'd1;
      done_error_n = done_error | bus_berror;
    end

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          done_error_n = 1'b0;
          done_miss_n  = 1'b0;
          done_unk_n   = 1'b0;
          rsp_cnt_n    = '0;
          if (unknown) begin
            done_unk_n   = 1'b1;
            done_valid_n = 1'b1;
            state_n      = S_DONE;
          end else if (misaligned && !ALLOW_MISALIGNED) begin
            done_miss_n  = 1'b1;
            done_valid_n = 1'b1;
            state_n      = S_DONE;
          end else begin
            bus_valid_n = 1'b1;
            bus_addr_n  = base;
            bus_data_n  = data_wide[DATA_WIDTH-1:0];
            bus_strb_n  = strb_wide[BYTES-1:0];
            split_n     = split;
            b1_addr_n   = base + 32'(BYTES);
            b1_data_n   = data_wide[DW2-1:DATA_WIDTH];
            b1_strb_n   = strb_wide[SW-1:BYTES];
            state_n     = S_SEND0;
          end
        end
      end
      S_SEND0: begin
        if (bus_ready) begin
          if (split_q) begin
            bus_addr_n = b1_addr;
            bus_data_n = b1_data;
            bus_strb_n = b1_strb;
            state_n    = S_SEND1;
          end else begin
            bus_valid_n = 1'b0;
            state_n     = S_WAIT;
          end
        end
      end
      S_SEND1: begin
        if (bus_ready) begin
          bus_valid_n = 1'b0;
          state_n     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_cnt_n == (split_q ? 2'd2 : 2'd1)) begin
          done_valid_n = 1'b1;
          state_n      = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      bus_valid        <= 1'b0;
      bus_addr         <= '0;
      bus_data         <= '0;
      bus_strb         <= '0;
      done_valid       <= 1'b0;
      done_error       <= 1'b0;
      done_missaligned <= 1'b0;
      done_unknowntype <= 1'b0;
      rsp_cnt          <= '0;
      split_q          <= 1'b0;
      b1_addr          <= '0;
      b1_data          <= '0;
      b1_strb          <= '0;
    end else begin
      state            <= state_n;
      bus_valid        <= bus_valid_n;
      bus_addr         <= bus_addr_n;
      bus_data         <= bus_data_n;
      bus_strb         <= bus_strb_n;
      done_valid       <= done_valid_n;
      done_error       <= done_error_n;
      done_missaligned <= done_miss_n;
      done_unknowntype <= done_unk_n;
      rsp_cnt          <= rsp_cnt_n;
      split_q          <= split_n;
      b1_addr          <= b1_addr_n;
      b1_data          <= b1_data_n;
      b1_strb          <= b1_strb_n;
    end
  end

endmodule

// File: tb/tb_armleocpu_store_splitter.sv
// Directed bench for armleocpu_store_splitter: 32-bit (misaligned allowed and
// rejected) and 64-bit instances, inputs driven and outputs sampled on negedge.
module tb_armleocpu_store_splitter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_checks = 0;

  // a: 32-bit, misaligned allowed
  logic        a_req_valid = 0, a_req_ready, a_bus_valid, a_bus_ready = 1;
  logic [31:0] a_req_addr = 0, a_req_data = 0, a_bus_addr, a_bus_data;
  logic [1:0]  a_req_type = 0;
  logic [3:0]  a_bus_strb;
  logic        a_bvalid = 0, a_berror = 0;
  logic        a_done_valid, a_done_error, a_done_miss, a_done_unk;

  // b: 32-bit, misaligned rejected
  logic        b_req_valid = 0, b_req_ready, b_bus_valid;
  logic [31:0] b_req_addr = 0, b_req_data = 0, b_bus_addr, b_bus_data;
  logic [1:0]  b_req_type = 0;
  logic [3:0]  b_bus_strb;
  logic        b_done_valid, b_done_error, b_done_miss, b_done_unk;

  // c: 64-bit, misaligned allowed
  logic        c_req_valid = 0, c_req_ready, c_bus_valid, c_bus_ready = 1;
  logic [31:0] c_req_addr = 0, c_bus_addr;
  logic [63:0] c_req_data = 0, c_bus_data;
  logic [1:0]  c_req_type = 0;
  logic [7:0]  c_bus_strb;
  logic        c_bvalid = 0, c_berror = 0;
  logic        c_done_valid, c_done_error, c_done_miss, c_done_unk;

  armleocpu_store_splitter #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .req_type(a_req_type), .req_data(a_req_data),
    .bus_valid(a_bus_valid), .bus_ready(a_bus_ready), .bus_addr(a_bus_addr),
    .bus_data(a_bus_data), .bus_strb(a_bus_strb),
    .bus_bvalid(a_bvalid), .bus_berror(a_berror),
    .done_valid(a_done_valid), .done_error(a_done_error),
    .done_missaligned(a_done_miss), .done_unknowntype(a_done_unk)
  );

  armleocpu_store_splitter #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .req_type(b_req_type), .req_data(b_req_data),
    .bus_valid(b_bus_valid), .bus_ready(1'b1), .bus_addr(b_bus_addr),
    .bus_data(b_bus_data), .bus_strb(b_bus_strb),
    .bus_bvalid(1'b0), .bus_berror(1'b0),
    .done_valid(b_done_valid), .done_error(b_done_error),
    .done_missaligned(b_done_miss), .done_unknowntype(b_done_unk)
  );

  armleocpu_store_splitter #(.DATA_WIDTH(64), .ALLOW_MISALIGNED(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_addr(c_req_addr),
    .req_type(c_req_type), .req_data(c_req_data),
    .bus_valid(c_bus_valid), .bus_ready(c_bus_ready), .bus_addr(c_bus_addr),
    .bus_data(c_bus_data), .bus_strb(c_bus_strb),
    .bus_bvalid(c_bvalid), .bus_berror(c_berror),
    .done_valid(c_done_valid), .done_error(c_done_error),
    .done_missaligned(c_done_miss), .done_unknowntype(c_done_unk)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state
    tick(); tick();
    chk("rst_a_ready", a_req_ready, 1);
    chk("rst_a_bus_valid", a_bus_valid, 0);
    chk("rst_a_bus_addr", a_bus_addr, 0);
    chk("rst_a_bus_data", a_bus_data, 0);
    chk("rst_a_bus_strb", a_bus_strb, 0);
    chk("rst_a_done", {a_done_valid, a_done_error, a_done_miss, a_done_unk}, 0);
    chk("rst_c_ready", c_req_ready, 1);
    chk("rst_b_ready", b_req_ready, 1);
    rst_n = 1'b1;
    tick();

    // ---------------- a: word store 0x100, single beat, minimum latency
    a_req_valid = 1; a_req_addr = 32'h100; a_req_type = 2'd2; a_req_data = 32'hDEADBEEF;
    tick();                                   // c1
    a_req_valid = 0; a_req_data = 32'h0;
    chk("w_ready_busy", a_req_ready, 0);
    chk("w_bus_valid", a_bus_valid, 1);
    chk("w_bus_addr", a_bus_addr, 32'h100);
    chk("w_bus_data", a_bus_data, 32'hDEADBEEF);
    chk("w_bus_strb", a_bus_strb, 4'b1111);
    tick();                                   // c2
    chk("w_bus_valid_drop", a_bus_valid, 0);
    chk("w_done_early", a_done_valid, 0);
    a_bvalid = 1; a_berror = 0;
    tick();                                   // c3
    a_bvalid = 0;
    chk("w_done_valid", a_done_valid, 1);
    chk("w_done_error", a_done_error, 0);
    chk("w_ready_c3", a_req_ready, 0);
    tick();                                   // c4
    chk("w_done_pulse", a_done_valid, 0);
    chk("w_ready_c4", a_req_ready, 1);

    // ---------------- a: byte store 0x203
    a_req_valid = 1; a_req_addr = 32'h203; a_req_type = 2'd0; a_req_data = 32'h000000A5;
    tick();
    a_req_valid = 0;
    chk("b_bus_addr", a_bus_addr, 32'h200);
    chk("b_bus_data", a_bus_data, 32'hA5000000);
    chk("b_bus_strb", a_bus_strb, 4'b1000);
    tick();
    a_bvalid = 1;
    tick();
    a_bvalid = 0;
    chk("b_done_valid", a_done_valid, 1);
    tick();

    // ---------------- a: split half store 0x1003 with back-pressure
    a_bus_ready = 0;
    a_req_valid = 1; a_req_addr = 32'h1003; a_req_type = 2'd1; a_req_data = 32'h0000BEEF;
    tick();
    a_req_valid = 0; a_req_addr = 32'h0; a_req_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("h_b0_valid", a_bus_valid, 1);
      chk("h_b0_addr", a_bus_addr, 32'h1000);
      chk("h_b0_data", a_bus_data, 32'hEF000000);
      chk("h_b0_strb", a_bus_strb, 4'b1000);
      if (i < 2) tick();
    end
    a_bus_ready = 1;
    tick();                                   // beat 1 presented
    chk("h_b1_valid", a_bus_valid, 1);
    chk("h_b1_addr", a_bus_addr, 32'h1004);
    chk("h_b1_data", a_bus_data, 32'h000000BE);
    chk("h_b1_strb", a_bus_strb, 4'b0001);
    a_bvalid = 1;                             // beat-0 response with beat-1 handshake
    tick();
    chk("h_wait_valid", a_bus_valid, 0);
    chk("h_wait_done", a_done_valid, 0);
    tick();                                   // second response sampled
    a_bvalid = 0;
    chk("h_done_valid", a_done_valid, 1);
    chk("h_done_error", a_done_error, 0);
    chk("h_done_miss", a_done_miss, 0);
    tick();

    // ---------------- b: misaligned word rejected
    b_req_valid = 1; b_req_addr = 32'h2; b_req_type = 2'd2; b_req_data = 32'h11111111;
    tick();
    b_req_valid = 0;
    chk("r_done_valid", b_done_valid, 1);
    chk("r_miss", b_done_miss, 1);
    chk("r_unk", b_done_unk, 0);
    chk("r_bus_valid", b_bus_valid, 0);
    tick();
    chk("r_pulse", b_done_valid, 0);
    chk("r_ready", b_req_ready, 1);
    // type 3 on 32-bit, also misaligned: only unknown type reported
    b_req_valid = 1; b_req_addr = 32'h3; b_req_type = 2'd3;
    tick();
    b_req_valid = 0;
    chk("u_done_valid", b_done_valid, 1);
    chk("u_unk", b_done_unk, 1);
    chk("u_miss", b_done_miss, 0);
    chk("u_bus_valid", b_bus_valid, 0);
    tick();

    // ---------------- c: 64-bit double wrapping past 0xFFFFFFFF
    c_req_valid = 1; c_req_addr = 32'hFFFFFFFD; c_req_type = 2'd3;
    c_req_data = 64'h1122334455667788;
    tick();
    c_req_valid = 0;
    chk("d_b0_addr", c_bus_addr, 32'hFFFFFFF8);
    chk("d_b0_data", c_bus_data, 64'h6677880000000000);
    chk("d_b0_strb", c_bus_strb, 8'hE0);
    tick();
    chk("d_b1_valid", c_bus_valid, 1);
    chk("d_b1_addr", c_bus_addr, 32'h0);
    chk("d_b1_data", c_bus_data, 64'h0000001122334455);
    chk("d_b1_strb", c_bus_strb, 8'h1F);
    c_bvalid = 1; c_berror = 0;
    tick();
    c_berror = 1;
    tick();
    c_bvalid = 0; c_berror = 0;
    chk("d_done_valid", c_done_valid, 1);
    chk("d_done_error", c_done_error, 1);
    chk("d_done_unk", c_done_unk, 0);
    tick();
    // next store clears the sticky error
    c_req_valid = 1; c_req_addr = 32'h4; c_req_type = 2'd2; c_req_data = 64'hCAFEF00D;
    tick();
    c_req_valid = 0;
    chk("e_addr", c_bus_addr, 32'h0);
    chk("e_data", c_bus_data, 64'hCAFEF00D00000000);
    chk("e_strb", c_bus_strb, 8'hF0);
    tick();
    c_bvalid = 1;
    tick();
    c_bvalid = 0;
    chk("e_done_valid", c_done_valid, 1);
    chk("e_done_error", c_done_error, 0);
    tick();

    // ---------------- a: reset during SEND1
    a_req_valid = 1; a_req_addr = 32'h1003; a_req_type = 2'd1; a_req_data = 32'h0000BEEF;
    tick();
    a_req_valid = 0;
    tick();
    chk("x_in_send1", a_bus_addr, 32'h1004);
    rst_n = 1'b0;
    #1;
    chk("x_async_valid", a_bus_valid, 0);
    chk("x_async_done", a_done_valid, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("x_no_done", a_done_valid, 0);
      chk("x_idle", a_req_ready, 1);
    end
    a_req_valid = 1; a_req_addr = 32'h40; a_req_type = 2'd2; a_req_data = 32'h12345678;
    tick();
    a_req_valid = 0;
    chk("y_addr", a_bus_addr, 32'h40);
    chk("y_data", a_bus_data, 32'h12345678);
    chk("y_strb", a_bus_strb, 4'b1111);
    tick();
    a_bvalid = 1;
    tick();
    a_bvalid = 0;
    chk("y_done_valid", a_done_valid, 1);
    chk("y_done_error", a_done_error, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
